// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared types and timing constants for the 1-D convolution
//                scheduler (FSM state encoding, MAC drain depth, memory latency).
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  // Scheduler phases: fill the window, stream the taps, wait for the MAC, present
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    OUTPUT  = 2'd3
  } state_e;

  // Pipeline depth of the downstream MAC after its last valid input
  localparam int DRAIN_CYC = 3;

  // Read latency of the x-memory / filter ROM
  localparam int MEM_LAT = 1;

endpackage
`default_nettype wire

// File: rtl/conv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : conv_sched
//  Description : Control scheduler for a valid-mode 1-D convolution. Streams
//                samples into x-memory, walks each SIZE_F-tap window through
//                the MAC, waits for the MAC pipeline and hands the result to
//                the consumer with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_sched
  import conv_pkg::*;
#(
  parameter int  T      = 8,
  parameter int  SIZE_X = 8,
  parameter int  SIZE_F = 3,
  localparam int c_AXW  = (SIZE_X > 1) ? $clog2(SIZE_X) : 1,
  localparam int c_AFW  = (SIZE_F > 1) ? $clog2(SIZE_F) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic             y_ready,
  output logic             y_valid,
  output logic             y_last,
  output logic [c_AXW-1:0] addr_x,
  output logic             wr_en_x,
  output logic [c_AFW-1:0] addr_f,
  output logic             en_acc,
  output logic             clear_acc
);

  // Counters share one width wide enough to hold SIZE_X itself (x_cnt full)
  localparam int               c_XCW    = $clog2(SIZE_X + 1);
  localparam logic [c_XCW-1:0] c_X      = c_XCW'(SIZE_X);
  localparam logic [c_XCW-1:0] c_F      = c_XCW'(SIZE_F);
  localparam logic [c_XCW-1:0] c_F_LAST = c_XCW'(SIZE_F - 1);
  localparam logic [c_XCW-1:0] c_Y_LAST = c_XCW'(SIZE_X - SIZE_F);
  localparam logic [1:0]       c_D_LAST = 2'(DRAIN_CYC - 1);

  if (T < 1 || SIZE_F < 1 || SIZE_F > SIZE_X) begin : g_bad_params
    $error("conv_sched: illegal parameter combination");
  end

  state_e             state_q, state_d;
  logic [c_XCW-1:0]   x_cnt_q, x_cnt_d;
  logic [c_XCW-1:0]   y_idx_q, y_idx_d;
  logic [c_XCW-1:0]   k_q, k_d;
  logic [1:0]         d_q, d_d;
  logic               y_valid_q, y_valid_d;
  logic               clr_pulse_q, clr_pulse_d;
  logic [MEM_LAT-1:0] en_pipe_q, en_pipe_d;

  logic w_in_compute;
  logic w_accept;
  logic w_hs;

  assign w_in_compute = (state_q == COMPUTE);
  assign x_ready      = reset && !w_in_compute && (x_cnt_q < c_X);
  assign wr_en_x      = x_valid && x_ready;
  assign w_accept     = wr_en_x;
  assign w_hs         = y_valid_q && y_ready;

  assign addr_x    = w_in_compute ? c_AXW'(y_idx_q + k_q) : c_AXW'(x_cnt_q);
  assign addr_f    = w_in_compute ? c_AFW'(k_q) : '0;
  assign y_valid   = y_valid_q;
  assign y_last    = y_valid_q && (y_idx_q == c_Y_LAST);
  assign en_acc    = en_pipe_q[MEM_LAT-1];
  assign clear_acc = clr_pulse_q ||
                     ((state_q == LOAD) && (y_idx_q == '0) && (x_cnt_q == '0));

  // en_acc trails COMPUTE by the memory read latency
  if (MEM_LAT == 1) begin : g_lat_one
    assign en_pipe_d = w_in_compute;
  end else begin : g_lat_pipe
    assign en_pipe_d = {en_pipe_q[MEM_LAT-2:0], w_in_compute};
  end

  // Next-state logic for the scheduler FSM and its counters
  always_comb begin
    state_d     = state_q;
    x_cnt_d     = x_cnt_q + c_XCW'(w_accept);
    y_idx_d     = y_idx_q;
    k_d         = k_q;
    d_d         = d_q;
    y_valid_d   = y_valid_q;
    clr_pulse_d = 1'b0;
    case (state_q)
      LOAD: begin
        // A sample written this cycle already counts towards the window
        if (x_cnt_d >= y_idx_q + c_F) begin
          state_d = COMPUTE;
          k_d     = '0;
        end
      end
      COMPUTE: begin
        if (k_q == c_F_LAST) begin
          state_d = DRAIN;
          d_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (d_q == c_D_LAST) begin
          state_d   = OUTPUT;
          y_valid_d = 1'b1;
        end else begin
          d_d = d_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (w_hs) begin
          state_d     = LOAD;
          y_valid_d   = 1'b0;
          clr_pulse_d = 1'b1;
          if (y_last) begin
            // Last window consumed: start a fresh vector
            y_idx_d = '0;
            x_cnt_d = '0;
          end else begin
            y_idx_d = y_idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State and counter registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      x_cnt_q     <= '0;
      y_idx_q     <= '0;
      k_q         <= '0;
      d_q         <= '0;
      y_valid_q   <= 1'b0;
      clr_pulse_q <= 1'b0;
      en_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_cnt_q     <= x_cnt_d;
      y_idx_q     <= y_idx_d;
      k_q         <= k_d;
      d_q         <= d_d;
      y_valid_q   <= y_valid_d;
      clr_pulse_q <= clr_pulse_d;
      en_pipe_q   <= en_pipe_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_sched
//  Description : Self-checking bench for conv_sched (SIZE_X=8, SIZE_F=3):
//                fixed-vector table, directed corner sequences and random
//                traffic compared against a timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_sched;

  localparam int X = 8;
  localparam int F = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       x_valid = 1'b0;
  logic       y_ready = 1'b0;
  logic       x_ready, y_valid, y_last, wr_en_x, en_acc, clear_acc;
  logic [2:0] addr_x;
  logic [1:0] addr_f;

  conv_sched #(.T(8), .SIZE_X(X), .SIZE_F(F)) dut (
    .clk       (clk),
    .reset     (reset),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .y_ready   (y_ready),
    .y_valid   (y_valid),
    .y_last    (y_last),
    .addr_x    (addr_x),
    .wr_en_x   (wr_en_x),
    .addr_f    (addr_f),
    .en_acc    (en_acc),
    .clear_acc (clear_acc)
  );

  always #5 clk = ~clk;

  // Observation word: [10]x_ready [9]wr_en_x [8:6]addr_x [5:4]addr_f
  //                   [3]en_acc [2]y_valid [1]y_last [0]clear_acc
  typedef logic [10:0] obs_t;
  typedef struct { bit xv; bit yr; obs_t exp; } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t s_obs;

  // Reference model: cycle index, samples held, output index, window start
  // cycle (-1 while loading) and cycle of the last y handshake
  int m_t, m_written, m_j, m_start, m_last_hs;

  function automatic obs_t mk(bit xr, bit wr, int ax, int af, bit en, bit yv, bit yl, bit clr);
    return {xr, wr, 3'(ax), 2'(af), en, yv, yl, clr};
  endfunction

  function automatic vec_t row(bit xv, bit yr, obs_t e);
    vec_t v;
    v.xv = xv; v.yr = yr; v.exp = e;
    return v;
  endfunction

  function automatic obs_t sample();
    return {x_ready, wr_en_x, addr_x, addr_f, en_acc, y_valid, y_last, clear_acc};
  endfunction

  function automatic void mdl_reset();
    m_t = 0; m_written = 0; m_j = 0; m_start = -1; m_last_hs = -10;
  endfunction

  // Window j reads x[j..j+F-1] over F cycles from its start, the MAC sees
  // them one cycle later, and the result is ready F+DRAIN cycles after start
  function automatic obs_t mdl_expect(bit xv);
    int rel;
    bit comp, xr, yv, en;
    rel  = m_t - m_start;
    comp = (m_start >= 0) && (rel >= 0) && (rel < F);
    xr   = !comp && (m_written < X);
    en   = (m_start >= 0) && (rel >= 1) && (rel <= F);
    yv   = (m_start >= 0) && (rel >= F + 3);
    return mk(xr, xv && xr, comp ? m_j + rel : m_written % X, comp ? rel : 0,
              en, yv, yv && (m_j == X - F),
              (m_last_hs == m_t - 1) || (m_start < 0 && m_j == 0 && m_written == 0));
  endfunction

  function automatic void mdl_advance(bit xv, bit yr);
    obs_t e;
    e = mdl_expect(xv);
    if (e[9]) m_written++;
    if (e[2] && yr) begin
      m_last_hs = m_t;
      m_start   = -1;
      if (m_j == X - F) begin
        m_j = 0; m_written = 0;
      end else begin
        m_j++;
      end
    end else if (m_start < 0 && m_written >= m_j + F) begin
      m_start = m_t + 1;
    end
    m_t++;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %b, expected %b (xr wr ax af en yv yl clr)",
               name, m_t, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Each step starts at a negedge, drives, samples 1ns later, ends at next negedge
  task automatic step_mdl(input bit xv, input bit yr, input string name);
    x_valid = xv; y_ready = yr;
    #1;
    s_obs = sample();
    check(name, s_obs, mdl_expect(xv));
    mdl_advance(xv, yr);
    @(negedge clk);
  endtask

  task automatic step_tbl(input vec_t v, input int idx);
    x_valid = v.xv; y_ready = v.yr;
    #1;
    s_obs = sample();
    check($sformatf("tbl[%0d]", idx), s_obs, v.exp);
    mdl_advance(v.xv, v.yr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; x_valid = 1'b0; y_ready = 1'b0;
    #1;
    check("reset_state", sample(), mk(0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    reset = 1'b1;
    mdl_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[24];
    int   hs, first_yv, pv, pr;
    bit   seen;

    // x_valid held high, consumer stalls 10 cycles in OUTPUT, then accepts
    tbl[0]  = row(1, 0, mk(1, 1, 0, 0, 0, 0, 0, 1));
    tbl[1]  = row(1, 0, mk(1, 1, 1, 0, 0, 0, 0, 0));
    tbl[2]  = row(1, 0, mk(1, 1, 2, 0, 0, 0, 0, 0));
    tbl[3]  = row(1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl[4]  = row(1, 0, mk(0, 0, 1, 1, 1, 0, 0, 0));
    tbl[5]  = row(1, 0, mk(0, 0, 2, 2, 1, 0, 0, 0));
    tbl[6]  = row(1, 0, mk(1, 1, 3, 0, 1, 0, 0, 0));
    tbl[7]  = row(1, 0, mk(1, 1, 4, 0, 0, 0, 0, 0));
    tbl[8]  = row(1, 0, mk(1, 1, 5, 0, 0, 0, 0, 0));
    tbl[9]  = row(1, 0, mk(1, 1, 6, 0, 0, 1, 0, 0));
    tbl[10] = row(1, 0, mk(1, 1, 7, 0, 0, 1, 0, 0));
    for (int i = 11; i <= 18; i++) tbl[i] = row(1, 0, mk(0, 0, 0, 0, 0, 1, 0, 0));
    tbl[19] = row(1, 1, mk(0, 0, 0, 0, 0, 1, 0, 0));
    tbl[20] = row(1, 0, mk(0, 0, 0, 0, 0, 0, 0, 1));
    tbl[21] = row(1, 0, mk(0, 0, 1, 0, 0, 0, 0, 0));
    tbl[22] = row(1, 0, mk(0, 0, 2, 1, 1, 0, 0, 0));
    tbl[23] = row(1, 0, mk(0, 0, 3, 2, 1, 0, 0, 0));

    @(negedge clk);
    do_reset();
    foreach (tbl[i]) step_tbl(tbl[i], i);
    for (int i = 0; i < 40; i++) step_mdl(1'b1, 1'b1, "vec1_tail");

    // Full vector with a willing consumer: six outputs, y_last on the sixth
    do_reset();
    hs = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step_mdl(1'b1, 1'b1, "full_vec");
      if (s_obs[2]) begin
        hs++;
        if (s_obs[1]) seen = 1'b1;
      end
    end
    check_int("y_last_seen", int'(seen), 1);
    check_int("outputs_per_vector", hs, 6);
    step_mdl(1'b0, 1'b0, "after_last");
    check_int("clear_after_last", int'(s_obs[0]), 1);
    check_int("xready_after_last", int'(s_obs[10]), 1);
    check_int("addr_x_after_last", int'(s_obs[8:6]), 0);

    // Only three samples: FSM parks in LOAD until the fourth arrives
    do_reset();
    for (int i = 0; i < 3; i++) step_mdl(1'b1, 1'b1, "three_samples");
    for (int i = 0; i < 20; i++) step_mdl(1'b0, 1'b1, "wait_fourth");
    check_int("idle_xready", int'(s_obs[10]), 1);
    check_int("idle_no_en", int'(s_obs[3]), 0);
    step_mdl(1'b1, 1'b1, "fourth_sample");
    for (int i = 0; i < 3; i++) begin
      step_mdl(1'b0, 1'b1, "window2");
      check_int("window2_addr_x", int'(s_obs[8:6]), i + 1);
      check_int("window2_addr_f", int'(s_obs[5:4]), i);
    end

    // Reset while the MAC is being fed abandons the vector
    do_reset();
    for (int i = 0; i < 5; i++) step_mdl(1'b1, 1'b0, "pre_reset");
    check_int("en_before_reset", int'(en_acc), 1);
    do_reset();
    first_yv = -1;
    for (int i = 0; i < 15; i++) begin
      step_mdl(1'b1, 1'b1, "post_reset");
      if (s_obs[2] && first_yv < 0) first_yv = i;
    end
    check_int("first_yv_after_reset", first_yv, 9);

    // Random traffic with varying densities and occasional resets
    do_reset();
    pv = 60; pr = 60;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        pv = $urandom_range(10, 100);
        pr = $urandom_range(10, 100);
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else step_mdl($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
